// File: rtl/addmulor_pkg.sv
//==============================================================================
// Module   : addmulor_pkg
// Brief    : Shared op encoding and per-bit ALU helper for the add-mul-op pipe.
// Revision : 1.0
//==============================================================================
`default_nettype none

package addmulor_pkg;

  typedef enum logic [1:0] {
    OP_OR   = 2'b00,
    OP_AND  = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  // Applied bit by bit so the kernel stays width-generic.
  function automatic logic apply_op(input op_e op, input logic r, input logic cx);
    logic res;
    case (op)
      OP_OR:   res = r | cx;
      OP_AND:  res = r & cx;
      OP_XOR:  res = r ^ cx;
      default: res = r;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/addmulor_kernel.sv
//==============================================================================
// Module   : addmulor_kernel
// Brief    : Combinational ((d + a) * b) OP c with selectable width/signedness.
// Revision : 1.0
//==============================================================================
`default_nettype none

module addmulor_kernel
  import addmulor_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int OUT_WIDTH = 9,
  parameter int SIGNED    = 0
) (
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [WIDTH-1:0]     i_c,
  input  logic [WIDTH-1:0]     i_d,
  input  logic [1:0]           i_op_sel,
  output logic [OUT_WIDTH-1:0] o_result
);

  localparam int   SUM_W     = WIDTH + 1;
  localparam int   PROD_W    = 2 * WIDTH + 1;
  localparam logic IS_SIGNED = (SIGNED != 0);

  logic                 w_a_msb;
  logic                 w_b_msb;
  logic                 w_d_msb;
  logic                 w_sum_msb;
  logic [SUM_W-1:0]     w_sum;
  logic [PROD_W-1:0]    w_sum_x;
  logic [PROD_W-1:0]    w_b_x;
  logic [PROD_W-1:0]    w_prod;
  logic [OUT_WIDTH-1:0] w_r;
  logic [OUT_WIDTH-1:0] w_cx;
  logic                 w_unused_prod;
  op_e                  w_op;

  assign w_a_msb   = IS_SIGNED & i_a[WIDTH-1];
  assign w_b_msb   = IS_SIGNED & i_b[WIDTH-1];
  assign w_d_msb   = IS_SIGNED & i_d[WIDTH-1];
  assign w_sum     = {w_d_msb, i_d} + {w_a_msb, i_a};
  assign w_sum_msb = IS_SIGNED & w_sum[SUM_W-1];

  // Operands widened to the full product width, so the low PROD_W bits of the
  // product are exact for both signed and unsigned interpretation.
  assign w_sum_x = {{WIDTH{w_sum_msb}}, w_sum};
  assign w_b_x   = {{(WIDTH + 1){w_b_msb}}, i_b};
  assign w_prod  = w_sum_x * w_b_x;

  assign w_r           = w_prod[OUT_WIDTH-1:0];
  assign w_unused_prod = ^w_prod;

  if (OUT_WIDTH > WIDTH) begin : g_cx_ext
    logic w_c_msb;
    assign w_c_msb = IS_SIGNED & i_c[WIDTH-1];
    assign w_cx    = {{(OUT_WIDTH - WIDTH){w_c_msb}}, i_c};
  end else if (OUT_WIDTH == WIDTH) begin : g_cx_same
    assign w_cx = i_c;
  end else begin : g_cx_trunc
    logic w_unused_c;
    assign w_cx       = i_c[OUT_WIDTH-1:0];
    assign w_unused_c = ^i_c;
  end

  assign w_op = op_e'(i_op_sel);

  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_bit
    assign o_result[i] = apply_op(w_op, w_r[i], w_cx[i]);
  end

endmodule

`default_nettype wire

// File: rtl/addmulor_pipe.sv
//==============================================================================
// Module   : addmulor_pipe
// Brief    : Elastic valid/ready pipeline of STAGES slots around addmulor_kernel.
// Revision : 1.0
//==============================================================================
`default_nettype none

module addmulor_pipe
  import addmulor_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int OUT_WIDTH = 9,
  parameter int STAGES    = 3,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  input  logic [1:0]           op_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data
);

  if (WIDTH < 2) begin : g_bad_width
    $error("addmulor_pipe: WIDTH must be >= 2");
  end
  if (OUT_WIDTH < 1 || OUT_WIDTH > 2 * WIDTH + 1) begin : g_bad_out_width
    $error("addmulor_pipe: OUT_WIDTH must be in 1..2*WIDTH+1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("addmulor_pipe: STAGES must be >= 1");
  end

  logic [STAGES-1:0]                valid_q;
  logic [STAGES-1:0]                valid_d;
  logic [STAGES-1:0][OUT_WIDTH-1:0] data_q;
  logic [STAGES-1:0][OUT_WIDTH-1:0] data_d;
  logic [STAGES-1:0]                w_adv;
  logic                             w_accept;
  logic [OUT_WIDTH-1:0]             w_kernel_result;

  addmulor_kernel #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SIGNED    (SIGNED)
  ) u_kernel (
    .i_a      (a),
    .i_b      (b),
    .i_c      (c),
    .i_d      (d),
    .i_op_sel (op_sel),
    .o_result (w_kernel_result)
  );

  // Advance chain walked from the output back; a local carry keeps the
  // vector free of self-reference.
  always_comb begin : adv_chain
    logic nxt;
    w_adv = '0;
    nxt   = valid_q[STAGES-1] & out_ready;
    w_adv[STAGES-1] = nxt;
    for (int i = STAGES - 2; i >= 0; i--) begin
      nxt      = valid_q[i] & (~valid_q[i+1] | nxt);
      w_adv[i] = nxt;
    end
  end

  assign in_ready = ~valid_q[0] | w_adv[0];
  assign w_accept = in_valid & in_ready;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = w_accept | (valid_q[0] & ~w_adv[0]);
    if (w_accept) begin
      data_d[0] = w_kernel_result;
    end
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = w_adv[i-1] | (valid_q[i] & ~w_adv[i]);
      if (w_adv[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_addmulor_pipe.sv
//==============================================================================
// Module   : tb_addmulor_pipe
// Brief    : Directed and streaming checks of addmulor_pipe in three configs.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_addmulor_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [8:0]  a, b, c, d;
  logic [1:0]  op_sel;

  logic        d_in_ready, d_out_valid;
  logic [8:0]  d_out_data;
  logic        s_in_ready, s_out_valid;
  logic [18:0] s_out_data;
  logic        u_in_ready, u_out_valid;
  logic [18:0] u_out_data;

  int total = 0;
  int bad   = 0;

  longint q_d[$];
  longint q_s[$];
  longint q_u[$];

  addmulor_pipe #(.WIDTH(9), .OUT_WIDTH(9), .STAGES(3), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .a(a), .b(b), .c(c), .d(d), .op_sel(op_sel),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data)
  );

  addmulor_pipe #(.WIDTH(9), .OUT_WIDTH(19), .STAGES(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .c(c), .d(d), .op_sel(op_sel),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data)
  );

  addmulor_pipe #(.WIDTH(9), .OUT_WIDTH(19), .STAGES(3), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .c(c), .d(d), .op_sel(op_sel),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent integer model of ((d + a) * b) OP c.
  function automatic longint model(input logic [8:0] ma, mb, mc, md,
                                   input logic [1:0] mop, input bit sgn, input int ow);
    longint sa, sb, sc, sd, p, mask, r, cx;
    sa = longint'(ma); sb = longint'(mb); sc = longint'(mc); sd = longint'(md);
    if (sgn) begin
      if (ma[8]) sa -= 512;
      if (mb[8]) sb -= 512;
      if (mc[8]) sc -= 512;
      if (md[8]) sd -= 512;
    end
    p    = (sd + sa) * sb;
    mask = (longint'(1) << ow) - 1;
    r    = p & mask;
    cx   = sc & mask;
    case (mop)
      2'd0:    return r | cx;
      2'd1:    return r & cx;
      2'd2:    return r ^ cx;
      default: return r;
    endcase
  endfunction

  // One beat through an empty, unstalled pipe; checks latency and all three results.
  task automatic send_check(input string tag, input logic [8:0] ta, tb, tc, td,
                            input logic [1:0] top, input logic [63:0] exp_d,
                            input logic [63:0] exp_s, input logic [63:0] exp_u);
    a = ta; b = tb; c = tc; d = td; op_sel = top;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, d_in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      chk({tag, "_early_valid"}, d_out_valid, 1'b0);
      tick();
    end
    chk({tag, "_valid_d"}, d_out_valid, 1'b1);
    chk({tag, "_valid_s"}, s_out_valid, 1'b1);
    chk({tag, "_valid_u"}, u_out_valid, 1'b1);
    chk({tag, "_data_d"}, d_out_data, exp_d);
    chk({tag, "_data_s"}, s_out_data, exp_s);
    chk({tag, "_data_u"}, u_out_data, exp_u);
    tick();
    chk({tag, "_drained"}, d_out_valid, 1'b0);
  endtask

  initial begin
    int     exp_seq;
    int     n_d, n_s, n_u;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0; op_sel = 2'd0;

    // Reset state before any clock edge
    #3;
    chk("rst_valid_d", d_out_valid, 1'b0);
    chk("rst_data_d",  d_out_data,  9'h000);
    chk("rst_valid_s", s_out_valid, 1'b0);
    chk("rst_data_s",  s_out_data,  19'h00000);
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", d_in_ready, 1'b1);

    // Directed beats
    send_check("t1_or",   9'h003, 9'h005, 9'h100, 9'h004, 2'd0, 64'h123,   64'h7FF23, 64'h00123);
    send_check("t2_wrap", 9'h1FF, 9'h1FF, 9'h000, 9'h1FF, 2'd0, 64'h002,   64'h00002, 64'h7F802);
    send_check("t2_xor",  9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 2'd2, 64'h1FD,   64'h7FFFD, 64'h7F9FD);
    send_check("t3_pass", 9'h1FF, 9'h002, 9'h000, 9'h000, 2'd3, 64'h1FE,   64'h7FFFE, 64'h003FE);
    send_check("t3_and",  9'h1FE, 9'h180, 9'h155, 9'h003, 2'd1, 64'h100,   64'h7FF00, 64'h00100);

    // Backpressure: three beats fill the pipe, the fourth is held off
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a = 9'(i); b = 9'h001; c = 9'h000; d = 9'h000; op_sel = 2'd3;
      in_valid = 1'b1;
      #1;
      chk("bp_in_ready", d_in_ready, (i <= 3));
      if (i <= 3) tick();
    end
    for (int k = 0; k < 2; k++) begin
      chk("bp_stall_valid", d_out_valid, 1'b1);
      chk("bp_stall_data",  d_out_data,  9'h001);
      tick();
      chk("bp_stall_ready", d_in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", d_in_ready, 1'b1);
    exp_seq = 1;
    for (int k = 0; k < 12 && exp_seq < 5; k++) begin
      if (d_out_valid) begin
        chk("bp_order", d_out_data, 9'(exp_seq));
        exp_seq++;
      end
      tick();
      in_valid = 1'b0;
    end
    chk("bp_count", exp_seq, 5);
    chk("bp_empty", d_out_valid, 1'b0);

    // Streaming: one beat per cycle, random operands and ops
    n_d = 0; n_s = 0; n_u = 0;
    for (int n = 0; n < 108; n++) begin
      if (n >= 3 && n < 103) chk("stream_tput", d_out_valid, 1'b1);
      if (d_out_valid) begin
        n_d++;
        if (q_d.size() == 0) chk("stream_extra_d", 1'b1, 1'b0);
        else chk("stream_d", d_out_data, q_d.pop_front());
      end
      if (s_out_valid) begin
        n_s++;
        if (q_s.size() == 0) chk("stream_extra_s", 1'b1, 1'b0);
        else chk("stream_s", s_out_data, q_s.pop_front());
      end
      if (u_out_valid) begin
        n_u++;
        if (q_u.size() == 0) chk("stream_extra_u", 1'b1, 1'b0);
        else chk("stream_u", u_out_data, q_u.pop_front());
      end
      if (n < 100) begin
        a = 9'($urandom_range(0, 511));
        b = 9'($urandom_range(0, 511));
        c = 9'($urandom_range(0, 511));
        d = 9'($urandom_range(0, 511));
        op_sel = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        chk("stream_in_ready", d_in_ready, 1'b1);
        q_d.push_back(model(a, b, c, d, op_sel, 1'b0, 9));
        q_s.push_back(model(a, b, c, d, op_sel, 1'b1, 19));
        q_u.push_back(model(a, b, c, d, op_sel, 1'b0, 19));
      end
      tick();
    end
    chk("stream_count_d", n_d, 100);
    chk("stream_count_s", n_s, 100);
    chk("stream_count_u", n_u, 100);

    // Asynchronous reset with the pipe full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 9'(7 + i); b = 9'h001; c = 9'h000; d = 9'h000; op_sel = 2'd3;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("full_valid", d_out_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_d", d_out_valid, 1'b0);
    chk("arst_data_d",  d_out_data,  9'h000);
    chk("arst_valid_s", s_out_valid, 1'b0);
    chk("arst_data_s",  s_out_data,  19'h00000);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("arst_no_stale", d_out_valid, 1'b0);
    end
    send_check("t6_after", 9'h001, 9'h002, 9'h000, 9'h001, 2'd3, 64'h004, 64'h00004, 64'h00004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
